// File: rtl/vga_timing.sv
// SVGA 800x600@60 timing generator: counters, blanking, sync and frame-start, all registered.
// Optional frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_timing #(
    parameter int   H_ACTIVE  = 800,
    parameter int   H_FP      = 40,
    parameter int   H_SYNC    = 128,
    parameter int   H_BP      = 88,
    parameter int   V_ACTIVE  = 600,
    parameter int   V_FP      = 1,
    parameter int   V_SYNC    = 4,
    parameter int   V_BP      = 23,
    parameter logic HSYNC_POL = 1'b1,
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        hblnk,
    output logic        vblnk,
    output logic        hsync,
    output logic        vsync,
`ifdef VGA_FRAME_CNT_EN
    output logic [15:0] frame_cnt,
`endif
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT_W = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT_W = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (H_TOTAL > 2048) begin : g_h_total_illegal
        $error("vga_timing: H_TOTAL %0d exceeds 2048", H_TOTAL);
    end
    if (V_TOTAL > 1024) begin : g_v_total_illegal
        $error("vga_timing: V_TOTAL %0d exceeds 1024", V_TOTAL);
    end

    logic [10:0] hcount_r;
    logic [9:0]  vcount_r;
    logic        hblnk_r;
    logic        vblnk_r;
    logic        hsync_r;
    logic        vsync_r;
    logic        frame_start_r;

    logic [10:0] h_next_s;
    logic [9:0]  v_next_s;
    logic        frame_wrap_s;
    logic        hblnk_s;
    logic        vblnk_s;
    logic        hsync_s;
    logic        vsync_s;

    // Next counter position and frame-wrap detection.
    always_comb begin
        h_next_s     = hcount_r + 11'd1;
        v_next_s     = vcount_r;
        frame_wrap_s = 1'b0;
        if (hcount_r == H_LAST) begin
            h_next_s = 11'd0;
            if (vcount_r == V_LAST) begin
                v_next_s     = 10'd0;
                frame_wrap_s = 1'b1;
            end else begin
                v_next_s = vcount_r + 10'd1;
            end
        end else begin
            h_next_s = hcount_r + 11'd1;
        end
    end

    // Flags decoded from the next position so they land in the same cycle as the counts.
    always_comb begin
        hblnk_s = (h_next_s >= H_ACT_W);
        vblnk_s = (v_next_s >= V_ACT_W);
        if ((h_next_s >= HS_BEG) && (h_next_s <= HS_END)) begin
            hsync_s = HSYNC_POL;
        end else begin
            hsync_s = ~HSYNC_POL;
        end
        if ((v_next_s >= VS_BEG) && (v_next_s <= VS_END)) begin
            vsync_s = VSYNC_POL;
        end else begin
            vsync_s = ~VSYNC_POL;
        end
    end

    // Counter and flag registers; reset lands on the valid pixel (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_r      <= 11'd0;
            vcount_r      <= 10'd0;
            hblnk_r       <= 1'b0;
            vblnk_r       <= 1'b0;
            hsync_r       <= ~HSYNC_POL;
            vsync_r       <= ~VSYNC_POL;
            frame_start_r <= 1'b0;
        end else begin
            hcount_r      <= h_next_s;
            vcount_r      <= v_next_s;
            hblnk_r       <= hblnk_s;
            vblnk_r       <= vblnk_s;
            hsync_r       <= hsync_s;
            vsync_r       <= vsync_s;
            frame_start_r <= frame_wrap_s;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    // Frame counter steps on the same edge that raises frame_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_r <= 16'd0;
        end else if (frame_wrap_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`endif

    assign hcount      = hcount_r;
    assign vcount      = vcount_r;
    assign hblnk       = hblnk_r;
    assign vblnk       = vblnk_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing at 800x600 timing; far positions are reached by forcing the counters.
module tb_vga_timing;

    logic        clk;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hblnk;
    logic        vblnk;
    logic        hsync;
    logic        vsync;
    logic        frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int vectors;
    int miscompares;
    int vs_cnt;
    int vb_cnt;
    int hs_cnt;
    logic [10:0] jh;
    logic [9:0]  jv;

    vga_timing dut (
        .clk         (clk),
        .rst         (rst),
        .hcount      (hcount),
        .vcount      (vcount),
        .hblnk       (hblnk),
        .vblnk       (vblnk),
        .hsync       (hsync),
        .vsync       (vsync),
`ifdef VGA_FRAME_CNT_EN
        .frame_cnt   (frame_cnt),
`endif
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move the counters to (jh, jv); the next edge then shows (jh+1, jv) with fresh flags.
    task automatic jump(input logic [10:0] h, input logic [9:0] v);
        jh = h;
        jv = v;
        force dut.hcount_r = jh;
        force dut.vcount_r = jv;
        #1;
        release dut.hcount_r;
        release dut.vcount_r;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        jh          = 11'd0;
        jv          = 10'd0;
        tick(2);
        chk("por_hcount", 32'(hcount), 32'd0);
        chk("por_hsync", 32'(hsync), 32'd0);

        // Run to mid-line, then reset for 5 cycles.
        rst = 1'b0;
        tick(300);
        chk("run_hcount300", 32'(hcount), 32'd300);
        rst = 1'b1;
        tick(5);
        chk("rst_hcount", 32'(hcount), 32'd0);
        chk("rst_vcount", 32'(vcount), 32'd0);
        chk("rst_hblnk", 32'(hblnk), 32'd0);
        chk("rst_vblnk", 32'(vblnk), 32'd0);
        chk("rst_hsync", 32'(hsync), 32'd0);
        chk("rst_vsync", 32'(vsync), 32'd0);
        chk("rst_fstart", 32'(frame_start), 32'd0);
`ifdef VGA_FRAME_CNT_EN
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
`endif
        rst = 1'b0;
        tick(1);
        chk("rel_h1", 32'(hcount), 32'd1);
        chk("rel_fstart", 32'(frame_start), 32'd0);
        tick(1);
        chk("rel_h2", 32'(hcount), 32'd2);
        tick(1);
        chk("rel_h3", 32'(hcount), 32'd3);

        // Horizontal decode along line 0.
        tick(796);
        chk("h799_hcount", 32'(hcount), 32'd799);
        chk("h799_hblnk", 32'(hblnk), 32'd0);
        tick(1);
        chk("h800_hblnk", 32'(hblnk), 32'd1);
        tick(39);
        chk("h839_hcount", 32'(hcount), 32'd839);
        chk("h839_hsync", 32'(hsync), 32'd0);
        tick(1);
        chk("h840_hsync", 32'(hsync), 32'd1);
        hs_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (hsync === 1'b1) hs_cnt++;
            tick(1);
        end
        chk("hsync_width", 32'(hs_cnt), 32'd128);
        chk("h1040_hcount", 32'(hcount), 32'd1040);
        tick(15);
        chk("h1055_hcount", 32'(hcount), 32'd1055);
        chk("h1055_vcount", 32'(vcount), 32'd0);
        chk("h1055_hblnk", 32'(hblnk), 32'd1);
        tick(1);
        chk("l1_hcount", 32'(hcount), 32'd0);
        chk("l1_vcount", 32'(vcount), 32'd1);
        chk("l1_hblnk", 32'(hblnk), 32'd0);

        // Line wrap at line 5.
        jump(11'd1054, 10'd5);
        tick(1);
        chk("lw_pre_h", 32'(hcount), 32'd1055);
        chk("lw_pre_v", 32'(vcount), 32'd5);
        tick(1);
        chk("lw_h", 32'(hcount), 32'd0);
        chk("lw_v", 32'(vcount), 32'd6);
        chk("lw_hblnk", 32'(hblnk), 32'd0);

        // Vertical decode around the blanking and sync lines.
        jump(11'd1054, 10'd599);
        tick(1);
        chk("v599_vblnk", 32'(vblnk), 32'd0);
        chk("v599_vsync", 32'(vsync), 32'd0);
        tick(1);
        chk("v600_vcount", 32'(vcount), 32'd600);
        chk("v600_vblnk", 32'(vblnk), 32'd1);
        chk("v600_vsync", 32'(vsync), 32'd0);
        vs_cnt = 0;
        vb_cnt = 0;
        for (int i = 0; i < 6 * 1056; i++) begin
            if (vsync === 1'b1) vs_cnt++;
            if (vblnk === 1'b1) vb_cnt++;
            tick(1);
        end
        chk("vsync_cycles", 32'(vs_cnt), 32'd4224);
        chk("vblnk_cycles", 32'(vb_cnt), 32'd6336);
        chk("v606_vcount", 32'(vcount), 32'd606);
        chk("v606_vsync", 32'(vsync), 32'd0);
        jump(11'd1054, 10'd604);
        tick(1);
        chk("v604_vsync", 32'(vsync), 32'd1);
        tick(1);
        chk("v605_vsync", 32'(vsync), 32'd0);
        chk("v605_vblnk", 32'(vblnk), 32'd1);

        // Frame wrap from (1055,627).
        jump(11'd1053, 10'd627);
        tick(1);
        chk("fw_1054_fstart", 32'(frame_start), 32'd0);
        chk("fw_627_vblnk", 32'(vblnk), 32'd1);
        tick(1);
        chk("fw_1055_h", 32'(hcount), 32'd1055);
        chk("fw_1055_fstart", 32'(frame_start), 32'd0);
`ifdef VGA_FRAME_CNT_EN
        chk("fw_fcnt_before", 32'(frame_cnt), 32'd0);
`endif
        tick(1);
        chk("fw_h0", 32'(hcount), 32'd0);
        chk("fw_v0", 32'(vcount), 32'd0);
        chk("fw_fstart", 32'(frame_start), 32'd1);
        chk("fw_vblnk", 32'(vblnk), 32'd0);
        chk("fw_hblnk", 32'(hblnk), 32'd0);
`ifdef VGA_FRAME_CNT_EN
        chk("fw_fcnt_after", 32'(frame_cnt), 32'd1);
`endif
        tick(1);
        chk("fw_h1_fstart", 32'(frame_start), 32'd0);
        chk("fw_h1", 32'(hcount), 32'd1);

`ifdef VGA_FRAME_CNT_EN
        rst = 1'b1;
        tick(1);
        chk("fcnt_rst", 32'(frame_cnt), 32'd0);
        rst = 1'b0;
        force dut.frame_cnt_r = 16'hFFFF;
        #1;
        release dut.frame_cnt_r;
        jump(11'd1054, 10'd627);
        tick(1);
        chk("fcnt_ffff", 32'(frame_cnt), 32'hFFFF);
        tick(1);
        chk("fcnt_roll", 32'(frame_cnt), 32'd0);
        chk("fcnt_roll_fstart", 32'(frame_start), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
